prio_decoder_q: RTL
===================

Name: prio_decoder_q

Overview:
- Receive-side counterpart to the team's 3-input priority encoder (outputs x = MSB, y = LSB).
- Accepts a stream of 2-bit codes {x,y}, buffers them in a small FIFO and presents each as a registered one-hot line vector d[3:0] over a valid/ready handshake.
- Keeps a saturating hit counter per decoded line for debug readback.
- Sits between the encoder's registered output stage and downstream request-service logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of each per-line hit counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- code_valid  in  1  {x,y} holds a valid code.
- code_ready  out  1  FIFO can accept a code.
- x  in  1  code MSB.
- y  in  1  code LSB.
- out_valid  out  1  d holds a decoded entry.
- out_ready  in  1  downstream accepts d.
- d  out  4  one-hot decoded line; d[0] means code 00 (no request / line 0).
- level  out  log2(DEPTH)+1  current FIFO occupancy.
- cnt_sel  in  2  selects the hit counter to read.
- cnt_clr  in  1  synchronous clear of all hit counters.
- cnt  out  CNT_W  registered value of the selected hit counter.

Behaviour:
- Reset (rst high at a clk edge):
  - wr_ptr = rd_ptr = 0, level = 0, out_valid = 0, d = 4'b0000.
  - All counters 0, cnt = 0.
  - code_ready = 0 while rst is high.
- Decode: code c = {x,y}; one-hot value = 1 << c (00→0001, 01→0010, 10→0100, 11→1000).
  - Decoding happens at write. FIFO stores the 4-bit one-hot value.
- Push occurs when code_valid && code_ready at a clk edge.
  - code_ready = !rst && (level != DEPTH). It is combinational from level only, not pop-aware.
- Pop occurs when out_valid && out_ready at a clk edge.
  - out_valid = (level != 0).
  - d = entry at rd_ptr when out_valid, else 4'b0000.
- Latency: a code pushed at edge N appears on d/out_valid after edge N. There is no same-cycle bypass when empty.
- Pointers wrap modulo DEPTH. level tracks occupancy:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged.
- Full (level == DEPTH): code_ready = 0. code_valid is ignored. No overwrite.
- Empty (level == 0): out_valid = 0. out_ready is ignored. No underflow.
- Simultaneous push and pop when level == 1: both complete; level stays 1; the new entry is presented after the edge.
- Ordering is strictly FIFO. d and out_valid are stable while out_valid && !out_ready.
- Hit counters hit[0..3]:
  - On each pop, hit[i] increments for the popped entry's set bit i.
  - Counters saturate at 2^CNT_W − 1 and do not wrap.
- cnt_clr has priority over an increment in the same cycle; all counters read 0 after the edge.
- cnt is registered: cnt = hit[cnt_sel] as of the previous edge, i.e. one cycle of read latency.
- rst mid-operation:
  - FIFO contents are discarded (pointers reset; stale RAM contents are unobservable).
  - out_valid drops after the edge.
  - No pop is counted in the reset cycle.

Test Plan:
- Reset, then push codes 00, 01, 10, 11 on consecutive cycles with out_ready=0 → level 1,2,3,4; code_ready=0 at level 4; a 5th push of 01 is dropped; level stays 4.
- From full, raise out_ready=1 → d = 0001, 0010, 0100, 1000 on consecutive cycles, then out_valid=0, d=0000, level=0; the dropped 01 never appears.
- Empty FIFO, push 10 at edge N with out_ready=1 → out_valid=0 before edge N; d=0100 valid after edge N; popped at edge N+1; level back to 0.
- level=1, push 11 and pop simultaneously → level remains 1; next d=1000.
- Counters:
  - With CNT_W=2, pop code 01 five times, cnt_sel=1 → cnt reads 3 (saturated).
  - Assert cnt_clr in the same cycle as a pop of 00 → hit[0] reads 0.
- Fill with 3 entries, assert rst for one cycle mid-stream → after the edge out_valid=0, level=0, code_ready=0 during rst and 1 after; the next push of 01 yields d=0010.

Source files
------------

// File: rtl/prio_decoder_q.sv
// Purpose : decodes 2-bit priority codes {x,y} to one-hot lines, buffers them, counts hits per line.
// Latency : a code pushed at edge N is presented on d/out_valid after edge N; cnt trails hit by one edge.
// Backpres: code_ready drops when the FIFO is full (not pop-aware); d/out_valid hold while !out_ready.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   code_valid/code_ready push handshake for the code {x,y}
//   x, y                  code MSB / LSB
//   out_valid/out_ready   pop handshake for the decoded line d[3:0]
//   d                     one-hot decoded line, 4'b0000 when nothing is held
//   level                 FIFO occupancy, 0..DEPTH
//   cnt_sel/cnt_clr/cnt   hit-counter readback select, clear-all, registered readback value

// Generic synchronous FIFO: storage plus occupancy tracking.
// Purpose : W-bit wide, DEPTH-entry circular buffer with an occupancy count.
// Latency : written data is readable on dout_o after the write edge.
// Backpres: caller gates push_i/pop_i against full/empty; this block trusts them.
module pdq_fifo #(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [W-1:0]               din_i,
   input  logic                       pop_i,
   output logic [W-1:0]               dout_o,
   output logic [$clog2(DEPTH):0]     level_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   // Pointers are log2(DEPTH) wide, so the +1 wraps modulo DEPTH naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset: stale entries are never presented because
   // the consumer only looks at dout_o while level_o != 0.
   always_ff @(posedge clk) begin
      if (push_i && !rst) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;
endmodule

module prio_decoder_q #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       code_valid,
   output logic                       code_ready,
   input  logic                       x,
   input  logic                       y,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [3:0]                 d,
   output logic [$clog2(DEPTH):0]     level,
   input  logic [1:0]                 cnt_sel,
   input  logic                       cnt_clr,
   output logic [CNT_W-1:0]           cnt
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef struct packed {
      logic       vld;
      logic [3:0] line;
   } meta_t;

   logic [3:0]       onehot_dat;
   logic [3:0]       head_dat;
   logic [LW-1:0]    level_dat;
   logic             push;
   logic             pop;
   meta_t            popped;

   logic [CNT_W-1:0] hit_q [4];
   logic [CNT_W-1:0] hit_d [4];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Decode at write time so the FIFO holds ready-to-present one-hot lines.
   always_comb begin
      onehot_dat = 4'b0000;
      onehot_dat[{x, y}] = 1'b1;
   end

   // Ready depends only on occupancy (and reset), never on a same-cycle pop.
   assign code_ready = !rst && (level_dat != FULL_LVL);
   assign out_valid  = (level_dat != '0);
   assign push       = code_valid && code_ready;
   // A pop in the reset cycle is discarded along with the FIFO contents.
   assign pop        = out_valid && out_ready && !rst;

   pdq_fifo #(
      .W     (4),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (onehot_dat),
      .pop_i   (pop),
      .dout_o  (head_dat),
      .level_o (level_dat)
   );

   assign d     = out_valid ? head_dat : 4'b0000;
   assign level = level_dat;

   always_comb begin
      popped.vld  = pop;
      popped.line = head_dat;
   end

   // Saturating per-line hit counters; clear beats increment.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         hit_d[i] = hit_q[i];
         if (cnt_clr) begin
            hit_d[i] = '0;
         end else if (popped.vld && popped.line[i] && (hit_q[i] != {CNT_W{1'b1}})) begin
            hit_d[i] = hit_q[i] + 1'b1;
         end
      end
      cnt_d = hit_q[cnt_sel];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) hit_q[i] <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) hit_q[i] <= hit_d[i];
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
endmodule
